// File: rtl/da_fir_if.sv
// da_fir_if: sample/result handshakes and subfilter control for da_fir_sequencer (y_round present only with DA_SEQ_ROUND_EN).
interface da_fir_if #(
  parameter int word_width = 16,
  parameter int ACC_W = 2*word_width+1
);
  logic                  x_in_valid;
  logic [word_width-1:0] x_in;
  logic                  x_in_ready;
  logic                  x_we;
  logic [word_width-1:0] x;
  logic                  en;
  logic                  Ts;
  logic [word_width-1:0] rom_data;
  logic [ACC_W-1:0]      y_out;
  logic                  y_valid;
  logic                  y_ready;
`ifdef DA_SEQ_ROUND_EN
  logic [word_width-1:0] y_round;
  modport slave (
    input  x_in_valid, x_in, rom_data, y_ready,
    output x_in_ready, x_we, x, en, Ts, y_out, y_valid, y_round
  );
  modport master (
    output x_in_valid, x_in, rom_data, y_ready,
    input  x_in_ready, x_we, x, en, Ts, y_out, y_valid, y_round
  );
`else
  modport slave (
    input  x_in_valid, x_in, rom_data, y_ready,
    output x_in_ready, x_we, x, en, Ts, y_out, y_valid
  );
  modport master (
    output x_in_valid, x_in, rom_data, y_ready,
    input  x_in_ready, x_we, x, en, Ts, y_out, y_valid
  );
`endif
endinterface

// File: rtl/da_fir_sequencer.sv
// da_fir_sequencer: bit-serial DA FIR sequencer and scaling accumulator; DA_SEQ_ROUND_EN adds saturated rounded output y_round.
module da_fir_sequencer #(
  parameter int word_width = 16,
  parameter int ACC_W = 2*word_width+1
`ifdef DA_SEQ_ROUND_EN
  , parameter int FRAC_BITS = word_width-1
`endif
) (
  input logic clk,
  input logic rst,
  da_fir_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int CW = $clog2(word_width);
  localparam logic [CW-1:0] K_LAST = CW'(word_width-1);
  localparam logic [CW-1:0] K_PEN = CW'(word_width-2);
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic signed [ACC_W-1:0]  r_acc, r_y, w_term, w_acc_next;
  logic [word_width-1:0]    r_x;
  logic                     r_rdy, r_we, r_en, r_ts, r_yv;
  // Sign-bit slice carries negative weight, so its ROM word is subtracted.
  always_comb begin
    w_term = {{(ACC_W-word_width){bus.rom_data[word_width-1]}}, bus.rom_data} << (word_width-1);
    w_acc_next = (r_cnt == K_LAST) ? (r_acc >>> 1) - w_term : (r_acc >>> 1) + w_term;
  end
`ifdef DA_SEQ_ROUND_EN
  logic signed [ACC_W-1:0]  w_sum, w_sh;
  logic                     w_ovf;
  logic [word_width-1:0]    w_rnd, r_round;
  always_comb begin
    w_sum = w_acc_next + (ACC_W'(1) << (FRAC_BITS-1));
    w_sh = w_sum >>> FRAC_BITS;
    w_ovf = w_sh[ACC_W-1:word_width-1] != {(ACC_W-word_width+1){w_sh[ACC_W-1]}};
    w_rnd = w_ovf ? {w_sh[ACC_W-1], {(word_width-1){~w_sh[ACC_W-1]}}} : w_sh[word_width-1:0];
  end
  always_ff @(posedge clk)
    if (rst) r_round <= '0;
    else if (r_state == RUN && r_cnt == K_LAST) r_round <= w_rnd;
  assign bus.y_round = r_round;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_acc <= '0;
      r_y <= '0;
      r_x <= '0;
      r_rdy <= 1'b1;
      r_we <= 1'b0;
      r_en <= 1'b0;
      r_ts <= 1'b0;
      r_yv <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.x_in_valid && r_rdy) begin
          r_x <= bus.x_in;
          r_acc <= '0;
          r_rdy <= 1'b0;
          r_we <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: begin
          r_we <= 1'b0;
          r_en <= 1'b1;
          r_ts <= 1'b0;
          r_cnt <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == K_LAST) begin
            r_en <= 1'b0;
            r_ts <= 1'b0;
            r_y <= w_acc_next;
            r_yv <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ts <= r_cnt == K_PEN;
          end
        end
        DONE: if (bus.y_ready) begin
          r_yv <= 1'b0;
          r_rdy <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.x_in_ready = r_rdy;
  assign bus.x_we = r_we;
  assign bus.x = r_x;
  assign bus.en = r_en;
  assign bus.Ts = r_ts;
  assign bus.y_out = r_y;
  assign bus.y_valid = r_yv;
endmodule
